// File: rtl/hazard_pkg.sv
// Shared latency defaults and sizing helpers for the hazard scoreboard.
package hazard_pkg;

    localparam int DEF_ALU_BR_LAT = 1;
    localparam int DEF_LD_BR_LAT  = 2;
    localparam int DEF_LD_USE_LAT = 1;
    localparam int DEF_ST_SLACK   = 1;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width needed to hold 0..max_lat; never narrower than one bit.
    function automatic int cnt_width(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One architectural register's pair of hazard down-counters (ID-stage and EX-stage view).
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int CW = 2
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [CW-1:0] load_id,
    input  logic [CW-1:0] load_ex,
    output logic [CW-1:0] cnt_id,
    output logic [CW-1:0] cnt_ex
);

    logic [CW-1:0] cnt_id_reg;
    logic [CW-1:0] cnt_ex_reg;

    // A fresh producer overrides whatever is still counting down.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_id_reg <= '0;
            cnt_ex_reg <= '0;
        end else if (load_en) begin
            cnt_id_reg <= load_id;
            cnt_ex_reg <= load_ex;
        end else begin
            if (cnt_id_reg != '0) cnt_id_reg <= cnt_id_reg - 1'b1;
            if (cnt_ex_reg != '0) cnt_ex_reg <= cnt_ex_reg - 1'b1;
        end
    end

    assign cnt_id = cnt_id_reg;
    assign cnt_ex = cnt_ex_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Counter-based RAW hazard detector for a 5-stage pipeline with ID-stage branch resolution.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_W      = 5,
    parameter int ALU_BR_LAT = DEF_ALU_BR_LAT,
    parameter int LD_BR_LAT  = DEF_LD_BR_LAT,
    parameter int LD_USE_LAT = DEF_LD_USE_LAT,
    parameter int ST_SLACK   = DEF_ST_SLACK
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             id_regwrite,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    input  logic             stall_count_load,
    input  logic [31:0]      stall_count_load_value,
    output logic             stall,
    output logic             flush_id,
    output logic             flush_if,
    output logic [31:0]      stall_count
);

    localparam int CW = cnt_width(max_of3(ALU_BR_LAT, LD_BR_LAT, LD_USE_LAT));
    localparam logic [CW-1:0] ALU_BR_V = CW'(ALU_BR_LAT);
    localparam logic [CW-1:0] LD_BR_V  = CW'(LD_BR_LAT);
    localparam logic [CW-1:0] LD_USE_V = CW'(LD_USE_LAT);
    localparam logic [31:0]   ST_SLACK_V = 32'(ST_SLACK);

    logic [CW-1:0] cnt_id_arr [NUM_REGS];
    logic [CW-1:0] cnt_ex_arr [NUM_REGS];
    logic          issue;
    logic [CW-1:0] load_id_val;
    logic [CW-1:0] load_ex_val;
    logic          branch_hazard;
    logic          data_hazard;
    logic [31:0]   rt_ex_wide;
    logic [31:0]   rt_threshold;
    logic [31:0]   stall_count_reg;

    assign issue       = id_valid && !stall;
    assign load_id_val = id_load ? LD_BR_V : ALU_BR_V;
    assign load_ex_val = id_load ? LD_USE_V : '0;

    assign cnt_id_arr[0] = '0;
    assign cnt_ex_arr[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic load_en;
            assign load_en = issue && id_regwrite && (id_rd == REG_W'(gi));

            hazard_sb_entry #(.CW(CW)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .load_en (load_en),
                .load_id (load_id_val),
                .load_ex (load_ex_val),
                .cnt_id  (cnt_id_arr[gi]),
                .cnt_ex  (cnt_ex_arr[gi])
            );
        end
    endgenerate

    // Store data is needed a stage later than its address, so it tolerates a little slack.
    assign rt_ex_wide   = 32'(cnt_ex_arr[id_rt]);
    assign rt_threshold = id_store ? ST_SLACK_V : 32'd0;

    assign branch_hazard = id_branch &&
                           ((id_use_rs && (cnt_id_arr[id_rs] != '0)) ||
                            (id_use_rt && (cnt_id_arr[id_rt] != '0)));
    assign data_hazard   = (id_use_rs && (cnt_ex_arr[id_rs] != '0)) ||
                           (id_use_rt && (rt_ex_wide > rt_threshold));

    assign stall    = id_valid && (branch_hazard || data_hazard);
    assign flush_id = stall;
    assign flush_if = id_valid && branch_taken && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (stall_count_load) begin
            stall_count_reg <= stall_count_load_value;
        end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes model-predicted outputs per cycle, monitor pops and compares.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int ALU_BR   = 1;
    localparam int LD_BR    = 2;
    localparam int LD_USE   = 1;
    localparam int ST_SL    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic             id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic             id_branch = 1'b0, id_load = 1'b0, id_store = 1'b0, id_regwrite = 1'b0;
    logic             branch_taken = 1'b0;
    logic             stall_count_load = 1'b0;
    logic [31:0]      stall_count_load_value = '0;
    logic             stall, flush_id, flush_if;
    logic [31:0]      stall_count;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .ALU_BR_LAT(ALU_BR), .LD_BR_LAT(LD_BR),
        .LD_USE_LAT(LD_USE), .ST_SLACK(ST_SL)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_load(id_load), .id_store(id_store), .id_regwrite(id_regwrite), .id_rd(id_rd),
        .branch_taken(branch_taken), .stall_count_load(stall_count_load),
        .stall_count_load_value(stall_count_load_value), .stall(stall),
        .flush_id(flush_id), .flush_if(flush_if), .stall_count(stall_count)
    );

    typedef struct {
        logic        stall;
        logic        flush_id;
        logic        flush_if;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: per register, the last cycle in which a consumer must still wait.
    longint busy_id [NUM_REGS];
    longint busy_ex [NUM_REGS];
    longint cyc = 0;
    longint exp_count = 0;
    bit     model_known = 0;

    task automatic model_clear();
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_id[r] = -100;
            busy_ex[r] = -100;
        end
        exp_count = 0;
    endtask

    task automatic check(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Drives one cycle of inputs, predicts this cycle's outputs, then advances the model.
    task automatic drive_cycle(input logic rst, input logic v, input logic br, input logic ld,
                               input logic st, input logic rw, input logic urs, input logic urt,
                               input logic tk, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic pl, input logic [31:0] plv,
                               output logic st_exp);
        logic hz_br, hz_nb;
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; id_valid = v; id_branch = br; id_load = ld; id_store = st;
        id_regwrite = rw; id_use_rs = urs; id_use_rt = urt; branch_taken = tk;
        id_rs = rs; id_rt = rt; id_rd = rd;
        stall_count_load = pl; stall_count_load_value = plv;

        hz_br = br && ((urs && rs != 0 && cyc <= busy_id[rs]) ||
                       (urt && rt != 0 && cyc <= busy_id[rt]));
        hz_nb = (urs && rs != 0 && cyc <= busy_ex[rs]) ||
                (urt && rt != 0 && cyc <= busy_ex[rt] - (st ? ST_SL : 0));
        st_exp = v && (hz_br || hz_nb);
        e.stall = st_exp;
        e.flush_id = st_exp;
        e.flush_if = v && tk && !st_exp;
        e.cnt = exp_count[31:0];
        if (model_known) exp_q.push_back(e);

        if (rst) begin
            model_clear();
            model_known = 1;
        end else begin
            if (v && !st_exp && rw && rd != 0) begin
                busy_id[rd] = cyc + (ld ? LD_BR : ALU_BR);
                busy_ex[rd] = cyc + (ld ? LD_USE : 0);
            end
            if (pl) exp_count = plv;
            else if (st_exp && exp_count < 64'hFFFF_FFFF) exp_count++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++)
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0, s);
    endtask

    // Holds an instruction in ID until it issues and counts the cycles the DUT stalled it.
    task automatic issue(input string nm, input logic br, input logic ld, input logic st,
                         input logic rw, input logic urs, input logic urt, input logic tk,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input int exp_stalls);
        logic s;
        int n = 0;
        for (int k = 0; k < 10; k++) begin
            drive_cycle(0, 1, br, ld, st, rw, urs, urt, tk, rs, rt, rd, 0, 32'd0, s);
            @(negedge clk);
            if (stall) n++;
            if (!s) break;
        end
        if (exp_stalls >= 0) check({nm, " stall cycles"}, n, exp_stalls);
        $display("[TB] issue %-14s dut_stalls=%0d stall_count=%0h", nm, n, stall_count);
    endtask

    // Monitor: compares every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", stall, e.stall);
                check("flush_id", flush_id, e.flush_id);
                check("flush_if", flush_if, e.flush_if);
                check("stall_count", stall_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic s;
        model_clear();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0, s);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0, s);
        idle(2);

        //          name            br ld st rw urs urt tk rs  rt  rd  stalls
        issue("lw $3",            0, 1, 0, 1, 1, 0, 0, 0,  0,  3,  0);
        issue("add $4,$3,$5",     0, 0, 0, 1, 1, 1, 0, 3,  5,  4,  1);
        @(negedge clk);
        check("stall_count after load-use", stall_count, 32'd1);
        idle(4);
        issue("lw $3",            0, 1, 0, 1, 1, 0, 0, 0,  0,  3,  0);
        issue("beq $3,$0",        1, 0, 0, 0, 1, 1, 0, 3,  0,  0,  2);
        idle(4);
        issue("add $3",           0, 0, 0, 1, 0, 0, 0, 0,  0,  3,  0);
        issue("beq $3,$0",        1, 0, 0, 0, 1, 1, 1, 3,  0,  0,  1);
        idle(4);
        issue("lw $3",            0, 1, 0, 1, 1, 0, 0, 0,  0,  3,  0);
        issue("sw $3,0($8)",      0, 0, 1, 0, 1, 1, 0, 8,  3,  0,  0);
        idle(4);
        issue("lw $8",            0, 1, 0, 1, 1, 0, 0, 0,  0,  8,  0);
        issue("sw $3,0($8)",      0, 0, 1, 0, 1, 1, 0, 8,  3,  0,  1);
        idle(4);
        issue("lw $0",            0, 1, 0, 1, 1, 0, 0, 0,  0,  0,  0);
        issue("beq $0,$0 tk",     1, 0, 0, 0, 1, 1, 1, 0,  0,  0,  0);
        issue("add $0",           0, 0, 0, 1, 0, 0, 0, 0,  0,  0,  0);
        issue("beq $0,$0 tk",     1, 0, 0, 0, 1, 1, 1, 0,  0,  0,  0);
        idle(4);

        // Reset on the cycle after the load, with a competing issue that must be ignored.
        issue("lw $3",            0, 1, 0, 1, 1, 0, 0, 0,  0,  3,  0);
        drive_cycle(1, 1, 0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd3, 0, 32'd0, s);
        issue("add $4,$3 post-rst", 0, 0, 0, 1, 1, 1, 0, 3, 5,  4,  0);
        @(negedge clk);
        check("stall_count after reset", stall_count, 32'd0);
        idle(4);

        // Saturation: preload near the top, then push past it.
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 32'hFFFF_FFFC, s);
        for (int i = 0; i < 3; i++) begin
            issue("lw $3",        0, 1, 0, 1, 1, 0, 0, 0,  0,  3,  0);
            issue("beq $3,$0",    1, 0, 0, 0, 1, 1, 0, 3,  0,  0,  2);
        end
        idle(2);
        @(negedge clk);
        check("stall_count saturated", stall_count, 32'hFFFF_FFFF);

        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 32'd0, s);

        // Randomized traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            int kind;
            logic v, rst, br, ld, st, rw, urs, urt, tk;
            logic [4:0] rs, rt, rd;
            kind = int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 99) < 85);
            br  = (kind == 3);
            ld  = (kind == 1);
            st  = (kind == 2);
            rw  = (kind <= 1);
            urs = ($urandom_range(0, 9) != 0);
            urt = (kind == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tk  = br && $urandom_range(0, 1) == 1;
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            drive_cycle(rst, v, br, ld, st, rw, urs, urt, tk, rs, rt, rd, 0, 32'd0, s);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
